gru_cell_seq: RTL and testbench

GRU_CELL_SEQ -- requirements
Module: gru_cell_seq

---
 rtl/gru_cell_seq.sv | 167 ++++++++++++++++
 tb/tb_gru_cell_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gru_cell_seq.sv
// gru_cell_seq: sequential GRU time step, one MAC per cycle over an external weight memory
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request one time step (ignored while busy)
//   clr_state       : zero committed state (idle only; wins over a simultaneous start)
//   x               : input vector, element k at [k*WIDTH +: WIDTH]
//   w_en, w_addr    : weight/bias read request; w_data returns one cycle later
//   busy, done      : step in progress / one-cycle completion pulse
//   h_out           : committed state vector
//   GRU_RELU_EN     : when defined the candidate uses relu instead of hard tanh
module gru_cell_seq #(
   parameter int WIDTH = 16,
   parameter int FRAC = 8,
   parameter int IN_DIM = 24,
   parameter int OUT_DIM = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clr_state,
   input  logic [IN_DIM*WIDTH-1:0] x,
   output logic w_en,
   output logic [$clog2(3*OUT_DIM+6*OUT_DIM*IN_DIM)-1:0] w_addr,
   input  logic [WIDTH-1:0] w_data,
   output logic busy,
   output logic done,
   output logic [OUT_DIM*WIDTH-1:0] h_out
);
   localparam int AW = $clog2(3*OUT_DIM+6*OUT_DIM*IN_DIM);
   localparam int ACC_W = 2*WIDTH + $clog2(IN_DIM+OUT_DIM+1);
   localparam int LAST = IN_DIM + OUT_DIM + 1;
   localparam int PW = $clog2(LAST+1);
   localparam int NW = $clog2(2*OUT_DIM);
   localparam int XW = IN_DIM > 1 ? $clog2(IN_DIM) : 1;
   localparam int HW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1;
   localparam int N3 = 3*OUT_DIM;
   localparam int REC = N3 + N3*IN_DIM;
   localparam logic signed [ACC_W-1:0] P_MAX = ACC_W'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] P_MIN = ~P_MAX;
   localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(P_MAX);
   localparam logic signed [WIDTH-1:0] MIN_W = ~MAX_W;
   localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(1 <<< FRAC);
   localparam logic signed [WIDTH-1:0] MONE_W = -ONE_W;
   localparam logic signed [WIDTH:0] ONE_E = (WIDTH+1)'(1 <<< FRAC);
   localparam logic signed [WIDTH:0] HALF_E = (WIDTH+1)'(1 <<< (FRAC-1));

   typedef enum logic [1:0] {IDLE, ZR, CAND, COMMIT} state_t;
   state_t r_state, w_next;

   logic [PW-1:0] r_ph;
   logic [NW-1:0] r_neu;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [WIDTH-1:0] r_x [IN_DIM];
   logic signed [WIDTH-1:0] r_h [OUT_DIM];
   logic signed [WIDTH-1:0] r_s [OUT_DIM];
   logic signed [WIDTH-1:0] r_z [OUT_DIM];
   logic signed [WIDTH-1:0] r_r [OUT_DIM];
   logic r_done;

   logic w_run, w_cand, w_last, w_grp_end, w_acpt, w_idle;
   logic [31:0] w_ph, w_d, w_j, w_gj, w_addr32;
   logic [XW-1:0] w_xi;
   logic [HW-1:0] w_ri, w_ji;
   logic signed [WIDTH-1:0] w_wd, w_rh, w_op, w_pre, w_sig, w_c, w_hn;
   logic signed [2*WIDTH-1:0] w_rhp, w_prod;
   logic signed [ACC_W-1:0] w_term, w_acc, w_mix;
   logic signed [WIDTH:0] w_hs;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
      return v > P_MAX ? MAX_W : v < P_MIN ? MIN_W : v[WIDTH-1:0];
   endfunction

   // done is registered, so the cycle after COMMIT is still part of the step
   assign w_idle = (r_state == IDLE) && !r_done;
   assign w_acpt = w_idle && start;
   assign w_run = (r_state == ZR) || (r_state == CAND);
   assign w_cand = r_state == CAND;
   assign w_ph = 32'(r_ph);
   assign w_d = w_ph - 1;
   assign w_last = w_ph == LAST;
   assign w_grp_end = w_cand ? (32'(r_neu) == OUT_DIM-1) : (32'(r_neu) == 2*OUT_DIM-1);

   // ZR interleaves z_j, r_j: neuron index bit 0 selects the gate
   assign w_j = w_cand ? 32'(r_neu) : 32'(r_neu >> 1);
   assign w_ji = HW'(w_j);
   assign w_gj = (w_cand ? 32'd2 : 32'(r_neu[0])) * OUT_DIM + w_j;
   assign w_addr32 = w_ph == 0 ? w_gj :
                     w_ph <= IN_DIM ? N3 + (w_ph - 1) * N3 + w_gj :
                     REC + (w_ph - IN_DIM - 1) * N3 + w_gj;
   assign w_en = w_run && w_ph <= IN_DIM + OUT_DIM;
   assign w_addr = w_en ? AW'(w_addr32) : '0;

   // w_data in phase p answers the read issued in phase p-1 (index w_d)
   assign w_xi = (w_d >= 1 && w_d <= IN_DIM) ? XW'(w_d - 1) : '0;
   assign w_ri = (w_d > IN_DIM && w_d <= IN_DIM + OUT_DIM) ? HW'(w_d - IN_DIM - 1) : '0;
   assign w_wd = $signed(w_data);
   assign w_rhp = (2*WIDTH)'(r_r[w_ri]) * (2*WIDTH)'(r_h[w_ri]);
   assign w_rh = WIDTH'(w_rhp >>> FRAC);
   assign w_op = (w_d <= IN_DIM) ? r_x[w_xi] : w_cand ? w_rh : r_h[w_ri];
   assign w_prod = (2*WIDTH)'(w_wd) * (2*WIDTH)'(w_op);
   assign w_term = (w_d == 0) ? (ACC_W'(w_wd) <<< FRAC) : ACC_W'(w_prod);
   // finalize folds the last recurrent product in combinationally
   assign w_acc = r_acc + w_term;
   assign w_pre = sat(w_acc >>> 8);
   assign w_hs = (WIDTH+1)'(w_pre >>> 2) + HALF_E;
   assign w_sig = w_hs[WIDTH] ? '0 : (w_hs > ONE_E) ? ONE_W : w_hs[WIDTH-1:0];
`ifdef GRU_RELU_EN
   assign w_c = w_pre[WIDTH-1] ? '0 : w_pre;
`else
   assign w_c = (w_pre > ONE_W) ? ONE_W : (w_pre < MONE_W) ? MONE_W : w_pre;
`endif
   assign w_mix = ACC_W'(r_z[w_ji]) * ACC_W'(r_h[w_ji]) +
                  (ACC_W'(ONE_W) - ACC_W'(r_z[w_ji])) * ACC_W'(w_c);
   assign w_hn = sat(w_mix >>> FRAC);

   assign busy = w_run || (r_state == COMMIT) || r_done;
   assign done = r_done;

   genvar g;
   for (g = 0; g < OUT_DIM; g++) begin : g_out
      assign h_out[g*WIDTH +: WIDTH] = r_h[g];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_acpt) w_next = ZR;
      if (r_state == ZR && w_last && w_grp_end) w_next = CAND;
      if (w_cand && w_last && w_grp_end) w_next = COMMIT;
      if (r_state == COMMIT) w_next = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ph <= '0;
         r_neu <= '0;
         r_acc <= '0;
         r_done <= 1'b0;
         for (int i = 0; i < IN_DIM; i++) r_x[i] <= '0;
         for (int i = 0; i < OUT_DIM; i++) begin
            r_h[i] <= '0;
            r_s[i] <= '0;
            r_z[i] <= '0;
            r_r[i] <= '0;
         end
      end else begin
         r_done <= r_state == COMMIT;
         if (w_acpt)
            for (int i = 0; i < IN_DIM; i++) r_x[i] <= x[i*WIDTH +: WIDTH];
         if (w_idle && clr_state)
            for (int i = 0; i < OUT_DIM; i++) r_h[i] <= '0;
         if (r_state == COMMIT)
            for (int i = 0; i < OUT_DIM; i++) r_h[i] <= r_s[i];
         if (w_run) begin
            r_ph <= w_last ? '0 : r_ph + 1'b1;
            if (w_last) r_neu <= w_grp_end ? '0 : r_neu + 1'b1;
            r_acc <= (w_last || w_ph == 0) ? '0 : w_acc;
            if (w_last && !w_cand && !r_neu[0]) r_z[w_ji] <= w_sig;
            if (w_last && !w_cand && r_neu[0]) r_r[w_ji] <= w_sig;
            if (w_last && w_cand) r_s[w_ji] <= w_hn;
         end
      end
   end
endmodule

// File: tb/tb_gru_cell_seq.sv
// tb_gru_cell_seq: scoreboard bench for gru_cell_seq (WIDTH=16, FRAC=8, IN_DIM=2, OUT_DIM=2)
module tb_gru_cell_seq;
   localparam int W = 16;
   localparam int F = 8;
   localparam int M = 2;
   localparam int N = 2;
   localparam int AW = 5;
   localparam int D = 3*N + 6*N*M;
   localparam int LAT = 3*N*(M+N+2) + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic clr_state = 1'b0;
   logic [M*W-1:0] x = '0;
   logic w_en;
   logic [AW-1:0] w_addr;
   logic [W-1:0] w_data = '0;
   logic busy, done;
   logic [N*W-1:0] h_out;
   logic [W-1:0] mem [D];
   logic [N*W-1:0] exp_q [$];
   logic [N*W-1:0] exp_h = '0;
   int n_cmp = 0;
   int n_bad = 0;

   gru_cell_seq #(.WIDTH(W), .FRAC(F), .IN_DIM(M), .OUT_DIM(N)) dut (
      .clk(clk), .rst(rst), .start(start), .clr_state(clr_state), .x(x),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .busy(busy), .done(done), .h_out(h_out)
   );

   always #5 clk = ~clk;

   // read data valid exactly one cycle after w_en; garbage otherwise
   always @(posedge clk) w_data <= w_en ? mem[w_addr] : 16'h5a5a;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint el(input logic [N*W-1:0] v, input int j);
      return longint'($signed(v[j*W +: W]));
   endfunction

   task automatic chk_vec(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] e);
      for (int j = 0; j < N; j++) chk($sformatf("%s_h%0d", tag, j), el(got, j), el(e, j));
   endtask

   function automatic longint wt(input int a);
      return longint'($signed(mem[a]));
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return v < lo ? lo : v > hi ? hi : v;
   endfunction

   function automatic longint pre(input longint acc);
      return clamp(acc >>> 8, -32768, 32767);
   endfunction

   function automatic logic [W-1:0] rnd(input int lim);
      return 16'($urandom_range(0, 2*lim) - lim);
   endfunction

   // reference GRU step from the memory image, input vector and committed state
   function automatic logic [N*W-1:0] model(input logic [M*W-1:0] xv, input logic [N*W-1:0] hv);
      longint xs [M];
      longint hs [N];
      longint z [N];
      longint r [N];
      longint acc, v, c;
      logic [N*W-1:0] res;
      res = '0;
      for (int k = 0; k < M; k++) xs[k] = longint'($signed(xv[k*W +: W]));
      for (int k = 0; k < N; k++) hs[k] = el(hv, k);
      for (int g = 0; g < 2; g++)
         for (int j = 0; j < N; j++) begin
            acc = wt(g*N+j) * 256;
            for (int k = 0; k < M; k++) acc += wt(3*N + k*3*N + g*N + j) * xs[k];
            for (int k = 0; k < N; k++) acc += wt(3*N + 3*N*M + k*3*N + g*N + j) * hs[k];
            v = clamp((pre(acc) >>> 2) + 128, 0, 256);
            if (g == 0) z[j] = v;
            else r[j] = v;
         end
      for (int j = 0; j < N; j++) begin
         acc = wt(2*N+j) * 256;
         for (int k = 0; k < M; k++) acc += wt(3*N + k*3*N + 2*N + j) * xs[k];
         for (int k = 0; k < N; k++) acc += wt(3*N + 3*N*M + k*3*N + 2*N + j) * ((r[k] * hs[k]) >>> 8);
`ifdef GRU_RELU_EN
         c = clamp(pre(acc), 0, 32767);
`else
         c = clamp(pre(acc), -256, 256);
`endif
         res[j*W +: W] = 16'(clamp((z[j] * hs[j] + (256 - z[j]) * c) >>> 8, -32768, 32767));
      end
      return res;
   endfunction

   task automatic run_step(input logic [N*W-1:0] e, input logic c, input string tag);
      int n, wen;
      exp_q.push_back(e);
      start = 1'b1;
      clr_state = c;
      @(posedge clk); #1;
      start = 1'b0;
      clr_state = 1'b0;
      n = 1;
      wen = 0;
      chk({tag, "_busy_first"}, longint'(busy), 1);
      while (!done && n < 200) begin
         wen += int'(w_en);
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n, LAT);
      chk({tag, "_wen_cycles"}, wen, 3*N*(M+N+1));
      chk({tag, "_busy_at_done"}, longint'(busy), 1);
      exp_h = exp_q.pop_front();
      chk_vec(tag, h_out, exp_h);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, longint'(done), 0);
      chk({tag, "_busy_after"}, longint'(busy), 0);
   endtask

   initial begin
      int dn;
      logic [N*W-1:0] e;
      for (int a = 0; a < D; a++) mem[a] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_wen", longint'(w_en), 0);
      chk("rst_waddr", longint'(w_addr), 0);
      chk_vec("rst_h", h_out, '0);
      rst = 1'b0;
      @(posedge clk); #1;

      mem[2*N] = 16'd256;
      mem[2*N+1] = 16'd256;
      run_step({16'd128, 16'd128}, 1'b0, "cand_bias");
      run_step({16'd192, 16'd192}, 1'b0, "repeat");

      clr_state = 1'b1;
      @(posedge clk); #1;
      clr_state = 1'b0;
      chk_vec("clr_idle", h_out, '0);
      exp_h = '0;

      mem[2*N] = 16'hfe00;
      mem[2*N+1] = 16'hfe00;
`ifdef GRU_RELU_EN
      e = '0;
`else
      e = {16'hff80, 16'hff80};
`endif
      run_step(e, 1'b0, "neg_cand");

      for (int a = 3*N; a < 3*N + 3*N*M; a++) mem[a] = 16'h7fff;
      x = {16'h7fff, 16'h7fff};
      run_step(exp_h, 1'b0, "z_sat");

      for (int a = 0; a < D; a++) mem[a] = rnd(300);
      x = {rnd(400), rnd(400)};
      run_step(model(x, exp_h), 1'b0, "rand1");
      x = {rnd(400), rnd(400)};
      run_step(model(x, exp_h), 1'b0, "rand2");
      run_step(model(x, exp_h), 1'b0, "rand3");
      x = {rnd(400), rnd(400)};
      run_step(model(x, '0), 1'b1, "clr_start");
      run_step(model(x, exp_h), 1'b0, "rand4");

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("mid_busy", longint'(busy), 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", longint'(busy), 0);
      chk("abort_wen", longint'(w_en), 0);
      chk("abort_done", longint'(done), 0);
      chk_vec("abort_h", h_out, '0);
      exp_h = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_step(model(x, '0), 1'b0, "after_abort");

      x = {rnd(400), rnd(400)};
      exp_q.push_back(model(x, exp_h));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      for (int n = 1; n <= 60; n++) begin
         if (n == 5) begin
            start = 1'b1;
            clr_state = 1'b1;
            x = {rnd(400), rnd(400)};
         end
         if (n == 6) begin
            start = 1'b0;
            clr_state = 1'b0;
         end
         if (done) begin
            dn++;
            chk("busy_ignore_latency", n, LAT);
            if (exp_q.size() != 0) exp_h = exp_q.pop_front();
            chk_vec("busy_ignore", h_out, exp_h);
         end
         @(posedge clk); #1;
      end
      chk("one_done_per_start", dn, 1);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
